// File: rtl/store_write_buffer_pkg.sv
// Shared types and helpers for the write-through store buffer.
// Entries hold a word address and one data word.
package store_buf_pkg;

    localparam int SB_ADDR_W  = 32;
    localparam int SB_DATA_W  = 32;
    localparam int WORD_OFS   = 2;
    localparam int SB_WADDR_W = SB_ADDR_W - WORD_OFS;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] word_addr;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;

    // Byte address to word address: the low byte-offset bits are dropped.
    function automatic logic [SB_WADDR_W-1:0] word_addr_of(input logic [SB_ADDR_W-1:0] addr);
        return SB_WADDR_W'(addr >> WORD_OFS);
    endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Core-side store/load lookup and memory-side drain signals of the store buffer.
// The buffer uses the slave modport; the core/memory environment uses master.
interface store_write_buffer_if
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  wr_valid, wr_addr, wr_data, ld_valid, ld_addr, mem_ack,
        output wr_ready, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, empty, count
    );

    modport master (
        output wr_valid, wr_addr, wr_data, ld_valid, ld_addr, mem_ack,
        input  wr_ready, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, empty, count
    );

endinterface

// File: rtl/store_write_buffer_fwd.sv
// Load-forwarding matcher: finds the youngest valid entry whose word address
// equals the load word address, scanning from tail-1 back towards head.
module store_buf_fwd
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t                      entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]       head,
    input  logic [$clog2(DEPTH + 1)-1:0]   count,
    input  logic                           ld_valid,
    input  logic [SB_ADDR_W-1:0]           ld_addr,
    output logic                           fwd_hit,
    output logic [SB_DATA_W-1:0]           fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [SB_WADDR_W-1:0] ld_waddr_s;

    assign ld_waddr_s = word_addr_of(ld_addr);

    // Offset k from head is valid when k < count; the first hit from the top is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = {SB_DATA_W{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ld_valid && !fwd_hit && (CNT_W'(k) < count) &&
                (entries[head + PTR_W'(k)].word_addr == ld_waddr_s)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[head + PTR_W'(k)].data;
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Write-through store buffer: single-cycle store acceptance into a circular FIFO,
// in-order drain to memory over req/ack, youngest-first load forwarding.
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t             entries_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [PTR_W-1:0]      youngest_s;
    logic [CNT_W-1:0]      count_r;
    logic [SB_WADDR_W-1:0] push_waddr_s;
    logic                  empty_s;
    logic                  ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  coalesce_s;
    logic                  alloc_s;
    logic [ADDR_W-1:0]     mem_addr_s;
    logic [DATA_W-1:0]     mem_wdata_s;

    // Handshake decode. Coalescing needs count >= 2 so the head under handshake is never rewritten.
    always_comb begin
        empty_s      = (count_r == {CNT_W{1'b0}});
        ready_s      = (count_r < CNT_W'(DEPTH));
        youngest_s   = tail_r - PTR_W'(1);
        push_waddr_s = word_addr_of(bus.wr_addr);
        push_s       = bus.wr_valid && ready_s;
        pop_s        = !empty_s && bus.mem_ack;
        coalesce_s   = push_s && (count_r >= CNT_W'(2)) &&
                       (entries_r[youngest_s].word_addr == push_waddr_s);
        alloc_s      = push_s && !coalesce_s;
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (alloc_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({alloc_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; validity comes from head/count, so it is never cleared.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            entries_r[tail_r] <= '{word_addr: push_waddr_s, data: bus.wr_data};
        end else if (coalesce_s) begin
            entries_r[youngest_s].data <= bus.wr_data;
        end
    end

    // Head entry presented to memory, gated to zero while empty.
    always_comb begin
        if (empty_s) begin
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
        end else begin
            mem_addr_s  = {entries_r[head_r].word_addr, {WORD_OFS{1'b0}}};
            mem_wdata_s = entries_r[head_r].data;
        end
    end

    assign bus.wr_ready  = ready_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_r;
    assign bus.mem_req   = !empty_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

    store_buf_fwd #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries  (entries_r),
        .head     (head_r),
        .count    (count_r),
        .ld_valid (bus.ld_valid),
        .ld_addr  (bus.ld_addr),
        .fwd_hit  (bus.fwd_hit),
        .fwd_data (bus.fwd_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: a queue models the buffered stores
// and is popped/compared whenever the bench acknowledges a memory request.
module tb_store_write_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    store_write_buffer_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();

    store_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model of one accepted store: merge into the youngest entry only when two or more are held.
    function automatic void model_push(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        if (sb_q.size() >= 2 && sb_q[sb_q.size()-1].addr[31:2] == addr[31:2]) begin
            e = sb_q[sb_q.size()-1];
            e.data = data;
            sb_q[sb_q.size()-1] = e;
        end else begin
            e.addr = {addr[31:2], 2'b00};
            e.data = data;
            sb_q.push_back(e);
        end
    endfunction

    task automatic push(input logic [31:0] addr, input logic [31:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        model_push(addr, data);
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic ack_pop(input string tag);
        exp_t e;
        bus.mem_ack = 1'b1;
        #1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: pop with empty scoreboard (req=%0b)", tag, bus.mem_req);
        end else begin
            e = sb_q.pop_front();
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                errors++;
                $display("FAIL %s: got req=%0b addr=%h data=%h, expected req=1 addr=%h data=%h",
                         tag, bus.mem_req, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h0;
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", bus.empty); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b expected 1", bus.wr_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req); end
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %0b expected 0", bus.fwd_hit); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h data=%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_single();
        push(32'h40, 32'h11);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.count !== 3'd1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'h11) begin
                errors++;
                $display("FAIL single_hold[%0d]: got count=%0d req=%0b addr=%h data=%h expected 1/1/40/11",
                         i, bus.count, bus.mem_req, bus.mem_addr, bus.mem_wdata);
            end
            @(posedge clk); #1;
        end
        ack_pop("single_pop");
        checks++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL single_empty: got empty=%0b count=%0d expected 1/0", bus.empty, bus.count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'hD0 + 32'(i));
        checks++; if (bus.wr_ready !== 1'b0 || bus.count !== 3'd4) begin errors++; $display("FAIL full_state: got ready=%0b count=%0d expected 0/4", bus.wr_ready, bus.count); end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h60;
        bus.wr_data  = 32'h99;
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        checks++; if (bus.count !== 3'd4 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL full_stall: got count=%0d addr=%h expected 4/10", bus.count, bus.mem_addr); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop_cycle: got %0b expected 0", bus.wr_ready); end
        ack_pop("full_pop0");
        checks++; if (bus.wr_ready !== 1'b1 || bus.mem_addr !== 32'h14 || bus.count !== 3'd3) begin errors++; $display("FAIL full_after_pop: got ready=%0b addr=%h count=%0d expected 1/14/3", bus.wr_ready, bus.mem_addr, bus.count); end
        for (int i = 1; i < 4; i++) ack_pop("full_order");
    endtask

    task automatic test_coalesce();
        push(32'h20, 32'hA);
        push(32'h24, 32'hB);
        push(32'h26, 32'hC);
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL coalesce_count: got %0d expected 2", bus.count); end
        ack_pop("coalesce_pop0");
        ack_pop("coalesce_pop1");
        push(32'h28, 32'h1);
        push(32'h28, 32'h2);
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL no_coalesce_head: got count %0d expected 2", bus.count); end
        ack_pop("head_pop0");
        ack_pop("head_pop1");
    endtask

    task automatic test_forward();
        exp_t e;
        push(32'h30, 32'h5);
        push(32'h34, 32'h6);
        push(32'h30, 32'h7);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fwd_count: got %0d expected 3", bus.count); end
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h32;
        #1;
        checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h7) begin errors++; $display("FAIL fwd_youngest: got hit=%0b data=%h expected 1/7", bus.fwd_hit, bus.fwd_data); end
        bus.ld_addr = 32'h50;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss: got hit=%0b data=%h expected 0/0", bus.fwd_hit, bus.fwd_data); end
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h30;
        #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_valid: got hit=%0b expected 0", bus.fwd_hit); end
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h38;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 32'h38;
        bus.wr_data  = 32'h9;
        model_push(32'h38, 32'h9);
        #1;
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle_push: got hit=%0b expected 0", bus.fwd_hit); end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
        checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h9) begin errors++; $display("FAIL fwd_after_push: got hit=%0b data=%h expected 1/9", bus.fwd_hit, bus.fwd_data); end
        ack_pop("fwd_pop0");
        bus.ld_addr = 32'h34;
        bus.mem_ack = 1'b1;
        #1;
        checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h6) begin errors++; $display("FAIL fwd_popping_entry: got hit=%0b data=%h expected 1/6", bus.fwd_hit, bus.fwd_data); end
        e = sb_q.pop_front();
        checks++; if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin errors++; $display("FAIL fwd_pop1: got addr=%h data=%h expected %h/%h", bus.mem_addr, bus.mem_wdata, e.addr, e.data); end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_popped_gone: got hit=%0b expected 0", bus.fwd_hit); end
        bus.ld_valid = 1'b0;
        ack_pop("fwd_pop2");
        ack_pop("fwd_pop3");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push(32'h40, 32'h1);
        push(32'h44, 32'h2);
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 32'h48;
            bus.wr_data  = 32'h3 + 32'(i);
            bus.mem_ack  = 1'b1;
            model_push(32'h48, 32'h3 + 32'(i));
            e = sb_q.pop_front();
            #1;
            checks++; if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin errors++; $display("FAIL b2b_pop[%0d]: got addr=%h data=%h expected %h/%h", i, bus.mem_addr, bus.mem_wdata, e.addr, e.data); end
            @(posedge clk); #1;
            bus.wr_valid = 1'b0;
            bus.mem_ack  = 1'b0;
            checks++; if (bus.count !== 3'(sb_q.size())) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, bus.count, sb_q.size()); end
        end
        checks++; if (bus.count !== 3'd1 || bus.mem_addr !== 32'h48 || bus.mem_wdata !== 32'h4) begin errors++; $display("FAIL b2b_coalesce_pop: got count=%0d addr=%h data=%h expected 1/48/4", bus.count, bus.mem_addr, bus.mem_wdata); end
        ack_pop("b2b_drain");
    endtask

    task automatic test_reset_mid();
        push(32'h50, 32'h21);
        push(32'h54, 32'h22);
        push(32'h58, 32'h23);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rst_mid_fill: got count %0d expected 3", bus.count); end
        bus.mem_ack = 1'b1;
        do_reset();
        checks++; if (bus.count !== 3'd0 || bus.mem_req !== 1'b0 || bus.empty !== 1'b1 || bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid: got count=%0d req=%0b empty=%0b ready=%0b expected 0/0/1/1", bus.count, bus.mem_req, bus.empty, bus.wr_ready); end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL stray_ack: got count=%0d empty=%0b addr=%h expected 0/1/0", bus.count, bus.empty, bus.mem_addr); end
        push(32'h5C, 32'h77);
        ack_pop("after_stray_ack");
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL final_empty: got %0b expected 1", bus.empty); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 32'h0;
        bus.wr_data  = 32'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h0;
        bus.mem_ack  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_full();
        test_coalesce();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
Write-through store buffer between the direct-mapped data cache and data memory. The core's stores are accepted into a small FIFO in a single cycle. The buffer then drains them to data memory one at a time over a req/ack handshake, so a slow memory write no longer stalls the core. Loads check the buffer, and a load to a word still held in it gets the youngest buffered data forwarded, which keeps read-after-write correct while stores are pending.

Parameters:
DEPTH, 4, number of buffered store entries; power of two, at least 2.
ADDR_W, 32, byte-address width.
DATA_W, 32, store data width (one word per entry).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
wr_valid  in  1  core/cache presents a store this cycle.
wr_addr  in  ADDR_W  store byte address; bits [1:0] are ignored.
wr_data  in  DATA_W  store data.
wr_ready  out  1  buffer can accept a store (count < DEPTH); the core stalls while wr_valid && !wr_ready.
ld_valid  in  1  a load lookup is active.
ld_addr  in  ADDR_W  load byte address.
fwd_hit  out  1  combinational: ld_valid and some buffered entry matches the load word address.
fwd_data  out  DATA_W  data of the youngest matching entry; 0 when fwd_hit=0.
mem_req  out  1  head entry is presented to memory (equal to !empty).
mem_addr  out  ADDR_W  head entry address, with [1:0] forced to 0.
mem_wdata  out  DATA_W  head entry data.
mem_ack  in  1  memory accepts the head this cycle.
empty  out  1  no entries held.
count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Push: happens when wr_valid && wr_ready. The entry {wr_addr[ADDR_W-1:2], wr_data} is written at tail; tail increments. Accept latency is zero cycles: the store retires in the same cycle it is presented.
- Coalesce: if a push word address equals the youngest entry (tail-1) and count >= 2, that entry's data is overwritten instead of allocating a new entry; tail and count are unchanged.
  - No coalescing when count == 1, because that entry is the head and may be under a memory handshake.
- Pop: happens when mem_req && mem_ack. Head increments; the next entry is presented from the following cycle.
  - mem_addr and mem_wdata come straight from registered storage and stay stable while mem_req=1 and mem_ack=0.
- Push and pop in the same cycle: both occur; count is unchanged, or decrements if the push coalesced.
- Full: wr_ready=0. A pop in that cycle does not make wr_ready high in the same cycle, since wr_ready depends on registered count only. A push is possible the following cycle.
- Empty: mem_req=0 and mem_ack is ignored. The head/tail/count state does not change on a stray mem_ack.
- Forwarding:
  - Compares ld_addr[ADDR_W-1:2] against every valid entry and selects the youngest match.
  - A store being pushed in the same cycle is not forwarded; the cache supplies that data.
  - An entry popped in the current cycle still forwards in that cycle.
- Order: stores reach memory in acceptance order. Coalescing only merges into the youngest entry, which preserves program order.
- Reset: at a clock edge with reset=1, head=tail=count=0. The next outputs are then empty=1, wr_ready=1, mem_req=0, fwd_hit=0, mem_addr=0, mem_wdata=0.
  - Entry storage need not be cleared. Valid state is derived from head/count, and mem_addr/mem_wdata are gated to 0 when empty.
  - Reset in the middle of a handshake discards all entries. An ack arriving in the reset cycle has no effect.

Decomposition:
- Package store_buf_pkg:
  - entry typedef {word_addr [ADDR_W-3:0], data [DATA_W-1:0]}.
  - constant WORD_OFS=2.
  - helper function for the word address.
- Sub-module store_buf_fwd: a combinational priority matcher. It takes the entry array, head, count and ld_addr, and returns fwd_hit and fwd_data, searching youngest first from tail-1 back to head.
- The top level holds the pointers, count, push/pop/coalesce logic and the memory interface.

Test Plan:
- Reset, then one store of 0x11 to 0x40 with mem_ack held low → count=1, mem_req=1, mem_addr=0x40, mem_wdata=0x11 stable for 3 cycles. Then mem_ack=1 for one cycle → empty=1 the next cycle.
- Push 4 stores (0x10, 0x14, 0x18, 0x1C) with no ack → wr_ready=0 and count=4. A fifth store stalls. Ack one entry → mem_addr is 0x10 then 0x14; wr_ready returns the cycle after the pop. Memory order is 0x10, 0x14, 0x18, 0x1C.
- Stores of 0xA to 0x20, 0xB to 0x24, 0xC to 0x24 with no ack → the third store coalesces and count=2. Ack twice → memory sees 0x20←0xA and 0x24←0xC only.
- Stores 0x30←5 then 0x34←6, then 0x30←7 (not youngest, so no coalesce), with ld_addr=0x32 → fwd_hit=1, fwd_data=7. With ld_addr=0x50 → fwd_hit=0 and fwd_data=0.
- Push and ack in the same cycle at count=2 → count stays 2 and the head advances. Assert reset with count=3 and mem_ack=1 → count=0, mem_req=0 the next cycle; an ack while empty leaves count=0.
